arp_rx_parse: RTL and testbench

- Receive-side counterpart of the ARP frame transmitter. Sits on the GMII receive bus after the RGMII-to-GMII conversion.
- Parses each incoming Ethernet frame byte by byte and checks preamble/SFD, destination MAC, EtherType, ARP header, target IP and FCS.
- On a fully valid ARP request or reply addressed to this node, it emits a one-cycle strobe with the sender's MAC/IP and the opcode.

---
 rtl/arp_rx_parse.sv | 152 +++++++++++++++
 tb/tb_arp_rx_parse.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx_parse.sv
// GMII receive-side ARP parser: validates preamble, Ethernet/ARP headers, target IP and FCS,
// then strobes the sender MAC/IP and opcode, or strobes frame_drop for any rejected frame.
module arp_rx_parse #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_00_02,
  parameter bit          CHECK_CRC = 1'b1
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rx_data,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic        arp_valid,
  output logic        arp_op,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic        frame_drop
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, ARP_BODY, TAIL, DONE, DROP} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  pre_cnt;
  logic [31:0] crc;
  logic        mism, dst_loc_bad, dst_bc_bad, len_ok, armed, op_sh;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic [7:0]  exp_mac, exp_ip;
  logic        byte_bad, frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    exp_mac  = 8'h00;
    exp_ip   = 8'h00;
    byte_bad = 1'b0;
    case (cnt)
      6'd0:  exp_mac = LOCAL_MAC[47:40];
      6'd1:  exp_mac = LOCAL_MAC[39:32];
      6'd2:  exp_mac = LOCAL_MAC[31:24];
      6'd3:  exp_mac = LOCAL_MAC[23:16];
      6'd4:  exp_mac = LOCAL_MAC[15:8];
      6'd5:  exp_mac = LOCAL_MAC[7:0];
      6'd38: exp_ip  = LOCAL_IP[31:24];
      6'd39: exp_ip  = LOCAL_IP[23:16];
      6'd40: exp_ip  = LOCAL_IP[15:8];
      6'd41: exp_ip  = LOCAL_IP[7:0];
      default: ;
    endcase
    // Fixed-value header fields; dst MAC is tracked separately (two acceptable values)
    case (cnt)
      6'd12: byte_bad = gmii_rx_data != 8'h08;
      6'd13: byte_bad = gmii_rx_data != 8'h06;
      6'd14: byte_bad = gmii_rx_data != 8'h00;
      6'd15: byte_bad = gmii_rx_data != 8'h01;
      6'd16: byte_bad = gmii_rx_data != 8'h08;
      6'd17: byte_bad = gmii_rx_data != 8'h00;
      6'd18: byte_bad = gmii_rx_data != 8'h06;
      6'd19: byte_bad = gmii_rx_data != 8'h04;
      6'd20: byte_bad = gmii_rx_data != 8'h00;
      6'd21: byte_bad = (gmii_rx_data != 8'h01) && (gmii_rx_data != 8'h02);
      6'd38, 6'd39, 6'd40, 6'd41: byte_bad = gmii_rx_data != exp_ip;
      default: ;
    endcase
  end

  assign frame_good = !mism && len_ok && !(dst_loc_bad && dst_bc_bad) &&
                      (!CHECK_CRC || crc == 32'hDEBB20E3);

  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      state <= IDLE;  cnt <= '0;  pre_cnt <= '0;  crc <= '0;
      mism <= 1'b0;  dst_loc_bad <= 1'b0;  dst_bc_bad <= 1'b0;  len_ok <= 1'b0;
      armed <= 1'b0;  op_sh <= 1'b0;  mac_sh <= '0;  ip_sh <= '0;
      arp_valid <= 1'b0;  arp_op <= 1'b0;  arp_src_mac <= '0;  arp_src_ip <= '0;
      frame_drop <= 1'b0;
    end else begin
      arp_valid  <= 1'b0;
      frame_drop <= 1'b0;
      // After reset, a frame already in flight is skipped until the bus goes idle
      if (!gmii_rx_dv) armed <= 1'b1;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (gmii_rx_dv && armed) begin
            if (!gmii_rx_er && gmii_rx_data == 8'h55) begin
              state   <= PREAMBLE;
              pre_cnt <= 3'd1;
            end else state <= DROP;
          end
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            frame_drop <= 1'b1;
            state      <= IDLE;
          end else if (gmii_rx_er) state <= DROP;
          else if (gmii_rx_data == 8'h55) begin
            if (pre_cnt == 3'd7) state <= DROP;
            else pre_cnt <= pre_cnt + 3'd1;
          end else if (gmii_rx_data == 8'hD5) begin
            state <= ETH_HDR;  cnt <= '0;  crc <= 32'hFFFFFFFF;
            mism <= 1'b0;  dst_loc_bad <= 1'b0;  dst_bc_bad <= 1'b0;  len_ok <= 1'b0;
          end else state <= DROP;
        end
        ETH_HDR, ARP_BODY, TAIL: begin
          if (!gmii_rx_dv) begin
            if (state == TAIL) begin
              state <= DONE;
              if (frame_good) begin
                arp_valid   <= 1'b1;
                arp_op      <= op_sh;
                arp_src_mac <= mac_sh;
                arp_src_ip  <= ip_sh;
              end else frame_drop <= 1'b1;
            end else begin
              frame_drop <= 1'b1;
              state      <= IDLE;
            end
          end else if (gmii_rx_er) state <= DROP;
          else begin
            crc  <= crc_byte(crc, gmii_rx_data);
            mism <= mism | byte_bad;
            // Counter saturates; a byte seen at 63 proves the 64-byte minimum
            if (cnt != 6'd63) cnt <= cnt + 6'd1;
            else len_ok <= 1'b1;
            if (cnt < 6'd6) begin
              if (gmii_rx_data != exp_mac) dst_loc_bad <= 1'b1;
              if (gmii_rx_data != 8'hFF)   dst_bc_bad  <= 1'b1;
            end
            if (cnt == 6'd21) op_sh <= (gmii_rx_data == 8'h02);
            if (cnt >= 6'd22 && cnt <= 6'd27) mac_sh <= {mac_sh[39:0], gmii_rx_data};
            if (cnt >= 6'd28 && cnt <= 6'd31) ip_sh  <= {ip_sh[23:0], gmii_rx_data};
            if (state == ETH_HDR && cnt == 6'd13)  state <= ARP_BODY;
            if (state == ARP_BODY && cnt == 6'd41) state <= TAIL;
          end
        end
        DROP: begin
          if (!gmii_rx_dv) begin
            frame_drop <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arp_rx_parse.sv
// Scoreboard bench for arp_rx_parse: directed frames drive two instances (FCS checked / ignored);
// expected strobes are queued by the stimulus and matched by independent monitors.
module tb_arp_rx_parse;
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst_n, dv, er;
  logic [7:0]  data;
  logic        m_valid, m_op, m_drop, n_valid, n_op, n_drop;
  logic [47:0] m_mac, n_mac;
  logic [31:0] m_ip, n_ip;

  arp_rx_parse dut (
    .gmii_rx_clk(clk), .rst_n(rst_n), .gmii_rx_data(data), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .arp_valid(m_valid), .arp_op(m_op), .arp_src_mac(m_mac), .arp_src_ip(m_ip), .frame_drop(m_drop));

  arp_rx_parse #(.CHECK_CRC(1'b0)) dut_nc (
    .gmii_rx_clk(clk), .rst_n(rst_n), .gmii_rx_data(data), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .arp_valid(n_valid), .arp_op(n_op), .arp_src_mac(n_mac), .arp_src_ip(n_ip), .frame_drop(n_drop));

  typedef struct {
    logic        v;
    logic        op;
    logic [47:0] mac;
    logic [31:0] ip;
    int          cyc;
  } evt_t;

  evt_t q_m[$], q_n[$];
  evt_t last_m, last_n, em, en;
  bit   hm, hn;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  logic [7:0] fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cmp_evt(input string tag, input bit have, input evt_t e, input logic v,
                         input logic d, input logic op, input logic [47:0] mac, input logic [31:0] ip);
    chk({tag, "_exclusive"}, 64'(v & d), 64'd0);
    if (!have) begin
      chk({tag, "_unexpected_strobe"}, {62'd0, v, d}, 64'd0);
      return;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(e.cyc));
    chk({tag, "_kind"}, {62'd0, v, d}, {62'd0, e.v, !e.v});
    chk({tag, "_op"}, 64'(op), 64'(e.op));
    chk({tag, "_mac"}, 64'(mac), 64'(e.mac));
    chk({tag, "_ip"}, 64'(ip), 64'(e.ip));
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid === 1'b1 || m_drop === 1'b1) begin
      hm = q_m.size() > 0;
      if (hm) em = q_m.pop_front();
      cmp_evt("main", hm, em, m_valid, m_drop, m_op, m_mac, m_ip);
    end
    if (n_valid === 1'b1 || n_drop === 1'b1) begin
      hn = q_n.size() > 0;
      if (hn) en = q_n.pop_front();
      cmp_evt("nocrc", hn, en, n_valid, n_drop, n_op, n_mac, n_ip);
    end
  end

  // vm/vn: whether each instance should accept; drops expect the previously latched data
  task automatic exp_evt(input bit vm, input bit vn, input logic op, input logic [47:0] mac,
                         input logic [31:0] ip, input int c);
    evt_t e;
    if (vm) begin last_m.op = op; last_m.mac = mac; last_m.ip = ip; end
    e = last_m; e.v = vm; e.cyc = c; q_m.push_back(e);
    if (vn) begin last_n.op = op; last_n.mac = mac; last_n.ip = ip; end
    e = last_n; e.v = vn; e.cyc = c; q_n.push_back(e);
  endtask

  task automatic put(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] oper,
                       input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                       input int len, input bit bad);
    logic [31:0] c;
    logic        fb;
    fr.delete();
    put(dst, 6); put(smac, 6); put(48'(et), 2);
    put(48'h0001, 2); put(48'h0800, 2); put(48'h06, 1); put(48'h04, 1); put(48'(oper), 2);
    put(smac, 6); put(48'(sip), 4); put(48'h0, 6); put(48'(tip), 4);
    while (fr.size() < len) fr.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    if (bad) c[9] = ~c[9];
    fr.push_back(c[7:0]); fr.push_back(c[15:8]); fr.push_back(c[23:16]); fr.push_back(c[31:24]);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic r);
    @(negedge clk);
    dv = v; data = d; er = e; rst_n = r;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Returns the cycle at which a strobe is due (one cycle after dv falls)
  task automatic send(input int pre, input int er_at, input int cut, input int rst_at, output int due);
    for (int i = 0; i < pre; i++) drive(1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, 8'hD5, 1'b0, 1'b1);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == cut) break;
      drive(1'b1, fr[i], i == er_at, i != rst_at);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    due = cyc + 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_op"},    64'(m_op),    64'd0);
    chk({tag, "_m_mac"},   64'(m_mac),   64'd0);
    chk({tag, "_m_ip"},    64'(m_ip),    64'd0);
    chk({tag, "_m_drop"},  64'(m_drop),  64'd0);
    chk({tag, "_n_mac"},   64'(n_mac),   64'd0);
    chk({tag, "_n_drop"},  64'(n_drop),  64'd0);
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LMAC  = 48'h000A_3501_FEC0;
  localparam logic [31:0] LIP   = 32'hC0A8_0002;

  initial begin
    int f;
    last_m = '{v: 1'b0, op: 1'b0, mac: 48'h0, ip: 32'h0, cyc: 0};
    last_n = last_m;
    rst_n = 1'b0; dv = 1'b0; er = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    gap(3);

    // Broadcast request, 64-byte frame
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 60, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b1, 1'b1, 1'b0, 48'h0011_2233_4455, 32'hC0A8_0003, f);
    gap(3);

    // Unicast reply, 7-byte preamble, then back-to-back with a 1-byte preamble
    build(LMAC, 16'h0806, 16'h0002, 48'h6677_8899_AABB, 32'hC0A8_0004, LIP, 60, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b1, 1'b1, 1'b1, 48'h6677_8899_AABB, 32'hC0A8_0004, f);
    build(LMAC, 16'h0806, 16'h0002, 48'h6677_8899_AABC, 32'hC0A8_0005, LIP, 60, 1'b0);
    send(1, -1, -1, -1, f);
    exp_evt(1'b1, 1'b1, 1'b1, 48'h6677_8899_AABC, 32'hC0A8_0005, f);
    gap(3);

    // Wrong target IP: drop, data outputs hold
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, 32'hC0A8_0009, 60, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    gap(3);

    // Corrupt FCS: only the FCS-checking instance drops
    build(BCAST, 16'h0806, 16'h0001, 48'hDEAD_BEEF_0001, 32'hC0A8_0006, LIP, 60, 1'b1);
    send(7, -1, -1, -1, f);
    exp_evt(1'b0, 1'b1, 1'b0, 48'hDEAD_BEEF_0001, 32'hC0A8_0006, f);
    gap(3);

    // rx_er at byte 20, then a good frame after one idle cycle
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0007, LIP, 60, 1'b0);
    send(7, 20, -1, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    build(LMAC, 16'h0806, 16'h0002, 48'h0200_0000_0042, 32'hC0A8_0008, LIP, 60, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b1, 1'b1, 1'b1, 48'h0200_0000_0042, 32'hC0A8_0008, f);
    gap(3);

    // 8-byte preamble is rejected
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 60, 1'b0);
    send(8, -1, -1, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    gap(3);

    // 63-byte frame is too short
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 59, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    gap(3);

    // Unicast to another MAC
    build(48'h000A_3501_FEC1, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 60, 1'b0);
    send(7, -1, -1, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    gap(3);

    // IPv4 EtherType, dv dropped at byte 30
    build(BCAST, 16'h0800, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 60, 1'b0);
    send(7, -1, 30, -1, f);
    exp_evt(1'b0, 1'b0, 1'b0, 48'h0, 32'h0, f);
    gap(3);

    // Reset mid-frame: no strobes, remainder ignored, outputs cleared
    build(BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0003, LIP, 60, 1'b0);
    send(7, -1, -1, 25, f);
    gap(3);
    last_m = '{v: 1'b0, op: 1'b0, mac: 48'h0, ip: 32'h0, cyc: 0};
    last_n = last_m;
    chk_zero("midreset");

    build(BCAST, 16'h0806, 16'h0001, 48'h0A0B_0C0D_0E0F, 32'hC0A8_000A, LIP, 60, 1'b0);
    send(2, -1, -1, -1, f);
    exp_evt(1'b1, 1'b1, 1'b0, 48'h0A0B_0C0D_0E0F, 32'hC0A8_000A, f);
    gap(10);

    chk("main_pending", 64'(q_m.size()), 64'd0);
    chk("nocrc_pending", 64'(q_n.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
